// File: rtl/rst_seq_pkg.sv
// Shared types and default timing for the camera-to-monitor reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      RELEASE,
      WAIT_DONE,
      GAP,
      HOLD,
      READY,
      FAIL
   } state_e;

   localparam int DEF_NUM_STAGES     = 3;
   localparam int DEF_PWRUP_CYCLES   = 100;
   localparam int DEF_STAGE_GAP      = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1_000_000;
   localparam int DEF_HOLD_CYCLES    = 100;
   localparam int DEF_MAX_RETRY      = 3;
   localparam int DEF_CNT_W          = 24;

   // Stage index is sized for the largest supported stage count.
   localparam int MAX_STAGES = 8;
   localparam int IDX_W      = $clog2(MAX_STAGES);

endpackage

// File: rtl/sync_bits.sv
// Per-bit 2-flop synchroniser with asynchronous active-low clear.
module sync_bits #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_seq_ctrl.sv
// Ordered reset release with done handshake, timeout, bounded retry and soft restart.
module reset_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int PWRUP_CYCLES   = DEF_PWRUP_CYCLES,
   parameter int STAGE_GAP      = DEF_STAGE_GAP,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int MAX_RETRY      = DEF_MAX_RETRY,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                  clk_100,
   input  logic                  rst_n,
   input  logic                  soft_rst_req,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  seq_busy,
   output logic                  seq_ready,
   output logic                  seq_fail,
   output logic [IDX_W-1:0]      fail_stage,
   output logic [1:0]            retry_cnt
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0]   srst_q, srst_d;
   logic [IDX_W-1:0]        fstg_q, fstg_d;
   logic [1:0]              retry_q, retry_d;
   logic                    busy_q, ready_q, fail_q;
   logic [NUM_STAGES-1:0]   done_s;
   logic                    done_cur;
   logic                    last_stage;

   sync_bits #(.W(NUM_STAGES)) u_done_sync (
      .clk_i  (clk_100),
      .rst_ni (rst_n),
      .d_i    (stage_done),
      .q_o    (done_s)
   );

   // Only the stage currently being waited on is observed.
   always_comb begin
      done_cur = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++)
         if (idx_q == IDX_W'(i)) done_cur = done_s[i];
   end

   assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      srst_d  = srst_q;
      fstg_d  = fstg_q;
      retry_d = retry_q;
      unique case (state_q)
         PWRUP: begin
            if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         RELEASE: begin
            for (int i = 0; i < NUM_STAGES; i++)
               if (idx_q == IDX_W'(i)) srst_d[i] = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (done_cur) begin
               cnt_d   = '0;
               state_d = last_stage ? READY : GAP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               fstg_d = idx_q;
               cnt_d  = '0;
               srst_d = '0;
               if (retry_q < 2'(MAX_RETRY)) begin
                  retry_d = retry_q + 2'd1;
                  idx_d   = '0;
                  state_d = HOLD;
               end else state_d = FAIL;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         GAP: begin
            if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
               cnt_d   = '0;
               idx_d   = idx_q + IDX_W'(1);
               state_d = RELEASE;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         HOLD: begin
            srst_d = '0;
            idx_d  = '0;
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         READY: srst_d = '1;
         FAIL:  srst_d = '0;
         default: state_d = PWRUP;
      endcase

      // Restart request outranks any same-cycle done or timeout.
      if (soft_rst_req && state_q != HOLD) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         srst_d  = '0;
         fstg_d  = fstg_q;
         retry_d = '0;
      end
   end

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PWRUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         srst_q  <= '0;
         fstg_q  <= '0;
         retry_q <= '0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         srst_q  <= srst_d;
         fstg_q  <= fstg_d;
         retry_q <= retry_d;
         busy_q  <= (state_d != READY) && (state_d != FAIL);
         ready_q <= (state_d == READY);
         fail_q  <= (state_d == FAIL);
      end
   end

   assign stage_rst_n = srst_q;
   assign seq_busy    = busy_q;
   assign seq_ready   = ready_q;
   assign seq_fail    = fail_q;
   assign fail_stage  = fstg_q;
   assign retry_cnt   = retry_q;

endmodule
